// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   UART receiver driven by an oversampled baud tick. The asynchronous rx
//   line is synchronised, a start bit is confirmed at its mid-point, and
//   each following bit is sampled at mid-bit. Bits arrive LSB first.
//   Each accepted byte is presented with a one-cycle data_valid strobe.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   : an even-parity bit follows the data bits and is checked
//     undefined : no parity bit; parity_error_o is tied low
//
// Ports
//   clk_i           system clock
//   rst_n_i         synchronous, active-low reset
//   baud_tick_i     one-clk pulse at OVERSAMPLE x baud rate
//   rx_i            asynchronous serial line, idles high
//   data_out_o      last correctly received byte
//   data_valid_o    one-cycle strobe, data_out_o is new
//   framing_error_o one-cycle strobe, stop bit sampled low
//   parity_error_o  one-cycle strobe, parity mismatch with good stop bit
//   busy_o          high whenever the receiver is not idle
//   dbg_state_o     current FSM state, for observation only
//
// Handshake: data_valid_o, framing_error_o and parity_error_o are
// fire-and-forget strobes with no back-pressure. Each is high for exactly
// one clk cycle and at most one of them is high in any cycle.

module uart_rx_oversampled #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 baud_tick_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_out_o,
    output logic                 data_valid_o,
    output logic                 framing_error_o,
    output logic                 parity_error_o,
    output logic                 busy_o,
    output logic [2:0]           dbg_state_o
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] HALF_M1  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_M1  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_out_q, data_out_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   parity_ok;
    logic                   rx_s;

`ifdef UART_RX_PARITY_EN
    logic                   par_bit_q, par_bit_d;
    logic                   perr_q, perr_d;
    // Even parity: data bits XOR parity bit must be zero.
    assign parity_ok = ~(^shift_q ^ par_bit_q);
`else
    assign parity_ok = 1'b1;
`endif

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Synchroniser runs every clk; presetting to 1 keeps a reset from
    // looking like a start bit.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        // Strobes default low so they clear on the next edge even without a tick.
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
        perr_d     = 1'b0;
`endif
        if (baud_tick_i) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                    end
                end
                S_START: begin
                    // Mid start bit: a line back high means a glitch.
                    if (tick_cnt_q == HALF_M1) begin
                        if (!rx_s) begin
                            state_d    = S_DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_d = '0;
                        par_bit_d  = rx_s;
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // Returning to IDLE at mid-stop lets a back-to-back
                    // start edge be caught.
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            state_d = S_IDLE;
                            if (parity_ok) begin
                                data_out_d = shift_q;
                                valid_d    = 1'b1;
                            end else begin
`ifdef UART_RX_PARITY_EN
                                perr_d = 1'b1;
`endif
                            end
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Wait out a held-low line so it cannot retrigger frames.
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign data_out_o      = data_out_q;
    assign data_valid_o    = valid_q;
    assign framing_error_o = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error_o  = perr_q;
`else
    assign parity_error_o  = 1'b0;
`endif
    assign busy_o          = (state_q != S_IDLE);
    assign dbg_state_o     = state_q;

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- UART receiver that consumes the oversampled `baud_tick` pulse from the baud generator (8 ticks per bit at 115200 baud).
- Synchronises the asynchronous `rx` line, detects and validates the start bit, then samples each bit at mid-bit.
- Deserialises the frame LSB first and presents each byte with a one-cycle valid strobe to downstream logic (FIFO or command decoder).
- Counterpart to the UART transmit path: the receiving end of the same serial link.

Parameters:
- DATA_BITS, 8, data bits per frame (5-9).
- OVERSAMPLE, 8, `baud_tick` pulses per bit period; must be even and at least 4.
- SYNC_STAGES, 2, flip-flop stages on `rx` before use; at least 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- baud_tick  input  1  one-clk-wide pulse at OVERSAMPLE x baud rate.
- rx  input  1  asynchronous serial line, idles high.
- data_out  output  DATA_BITS  last correctly received byte.
- data_valid  output  1  one-cycle strobe; `data_out` is new.
- framing_error  output  1  one-cycle strobe; stop bit sampled low.
- parity_error  output  1  one-cycle strobe; see Optional Feature.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: on a rising `clk` edge with `rst_n`=0, all of the following take effect:
  - `data_out`=0, `data_valid`=0, `framing_error`=0, `parity_error`=0, `busy`=0.
  - Synchroniser stages preset to 1; state=IDLE; counters cleared.
  - Reset overrides any in-progress frame; no strobe is emitted for an aborted frame.
- Sampling rule: all state and counter updates occur only on clk cycles with `baud_tick`=1, except the strobe clearing described below. `rx_s` is the synchronised line.
- IDLE:
  - On a tick with `rx_s`=0: go to START and clear `tick_cnt`.
- START:
  - `tick_cnt` increments on each tick.
  - On the (OVERSAMPLE/2)th tick after entry, i.e. mid start bit:
    - If `rx_s`=0: go to DATA, clear `tick_cnt` and `bit_cnt`.
    - If `rx_s`=1: the start was a glitch; return to IDLE with no strobe.
- DATA:
  - On every OVERSAMPLE-th tick, sample `rx_s` into the shift register, LSB first, and increment `bit_cnt`.
  - After DATA_BITS samples: go to PARITY if the macro is defined, else STOP.
- STOP: on the OVERSAMPLE-th tick, sample `rx_s`.
  - `rx_s`=1 and no parity fault: `data_out` takes the shift register, `data_valid`=1; go to IDLE.
  - `rx_s`=0: `framing_error`=1, `data_out` unchanged; go to BREAK.
- BREAK:
  - Remain until a tick with `rx_s`=1, then go to IDLE.
  - Prevents a held-low line from producing repeated frames.
- Strobes:
  - Asserted for exactly one clk cycle, the cycle after the sampling tick.
  - Cleared on the next clk edge regardless of `baud_tick`.
- Back-to-back frames: a start bit immediately after the stop bit is detected normally, because IDLE is re-entered at the stop-bit mid-point.
- Latency: `data_valid` rises 1 clk after the mid-stop-bit tick, i.e. about 9.5 bit periods after the start-bit falling edge.
- Counter widths: `tick_cnt` is clog2(OVERSAMPLE) bits and `bit_cnt` is clog2(DATA_BITS+1) bits; neither wraps within a frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples the parity bit on the OVERSAMPLE-th tick.
  - Even parity is checked: XOR of data bits and parity bit must equal 0.
  - The frame then proceeds to STOP.
  - On mismatch with a good stop bit: `parity_error`=1, `data_valid`=0, `data_out` unchanged.
  - On a bad stop bit: `framing_error` takes precedence and `parity_error` stays 0.
- Undefined: no PARITY state; `parity_error` is tied to 0.

Test Plan:
- Reset: `rst_n`=0 for 3 clks with `rx`=1 -> all outputs 0, `busy`=0; a `baud_tick` during reset causes no state change.
- Back-to-back frames: `baud_tick` every 4 clks, frames 0x55 then 0xA3 with no idle gap -> exactly two `data_valid` pulses; `data_out`=0x55 then 0xA3; `framing_error` never set.
- Start glitch: `rx` low for 2 ticks then high -> `busy` rises then returns to 0 by tick 4; no strobes; a following frame 0x0F is received correctly.
- Break: 0x00 sent with stop bit 0 and `rx` held low for 30 ticks -> one `framing_error` pulse; `data_out` keeps its previous value; no further strobes until `rx` returns high; next frame 0x81 is received.
- Reset mid-frame: `rst_n`=0 for 1 clk during data bit 3 of 0xFF -> `busy`=0 next cycle, no strobe; a subsequent frame 0x3C gives `data_out`=0x3C.
- Parity (UART_RX_PARITY_EN defined):
  - 0x07 with parity bit 1 -> `data_valid`, `data_out`=0x07.
  - 0x07 with parity bit 0 -> `parity_error` pulse, no `data_valid`, `data_out` stays 0x07.
